// File: rtl/arf_latch_rf_bank.sv
// Latch-based register-file bank: phase-A staging flops feed clock-low transparent
// storage latches, with per-entry valid bits, byte-enable merge, read bypass and a clear engine.
module arf_latch_rf_bank #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 66,
    parameter int NRD    = 1,
    parameter bit BYPASS = 1'b1,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int BEW    = DWIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [DWIDTH-1:0]       wr_data,
    input  logic [BEW-1:0]          wr_be,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*AWIDTH-1:0]   rd_addr,
    output logic [NRD*DWIDTH-1:0]   rd_data,
    output logic [NRD-1:0]          rd_vld,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    wr_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic                stg_vld_q, stg_vld_d;
    logic [AWIDTH-1:0]   stg_addr_q, stg_addr_d;
    logic [DWIDTH-1:0]   stg_data_q, stg_data_d;
    logic [BEW-1:0]      stg_be_q, stg_be_d;
    logic                wr_err_q, wr_err_d;
    logic [DWIDTH-1:0]   lat_q [DEPTH];

    logic                busy_s;
    logic                wr_in_rng_s;
    logic                wr_ok_s;
    logic                wr_any_be_s;

    always_comb begin
        busy_s      = (state_q == ST_CLEAR);
        wr_in_rng_s = ({1'b0, wr_addr} < DEPTH_W);
        wr_ok_s     = wr_en & wr_in_rng_s & ~busy_s;
        wr_any_be_s = |wr_be;
        wr_err_d    = wr_en & (~wr_in_rng_s | busy_s);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The clear engine and user writes share one staging port; writes are refused while clearing.
    always_comb begin
        stg_vld_d  = 1'b0;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        stg_be_d   = stg_be_q;
        valid_d    = valid_q;
        if (busy_s) begin
            stg_vld_d       = 1'b1;
            stg_addr_d      = cnt_q;
            stg_data_d      = '0;
            stg_be_d        = '1;
            valid_d[cnt_q]  = 1'b0;
        end else if (wr_ok_s) begin
            stg_vld_d  = wr_any_be_s;
            stg_addr_d = wr_addr;
            stg_data_d = wr_data;
            stg_be_d   = wr_be;
            if (wr_any_be_s) begin
                valid_d[wr_addr] = 1'b1;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            stg_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= '0;
            stg_vld_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            stg_vld_q <= stg_vld_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        stg_addr_q <= stg_addr_d;
        stg_data_q <= stg_data_d;
        stg_be_q   <= stg_be_d;
    end

    // Phase-B storage: open during clk low, closed before the read flops sample at the next rise.
    always_latch begin
        if (!clk && stg_vld_q) begin
            for (int b = 0; b < BEW; b++) begin
                if (stg_be_q[b]) begin
                    lat_q[stg_addr_q][b*8 +: 8] <= stg_data_q[b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AWIDTH-1:0] ra_s;
        logic              in_rng_s;
        logic              hit_s;
        logic              ent_vld_s;
        logic [DWIDTH-1:0] old_s;
        logic [DWIDTH-1:0] mrg_s;
        logic              vld_d, vld_q;
        logic [DWIDTH-1:0] dat_d, dat_q;

        always_comb begin
            ra_s      = rd_addr[p*AWIDTH +: AWIDTH];
            in_rng_s  = ({1'b0, ra_s} < DEPTH_W);
            old_s     = '0;
            ent_vld_s = 1'b0;
            if (in_rng_s) begin
                old_s     = lat_q[ra_s];
                ent_vld_s = valid_q[ra_s];
            end else begin
                old_s     = '0;
                ent_vld_s = 1'b0;
            end
            hit_s = BYPASS & wr_ok_s & (wr_addr == ra_s);
            for (int b = 0; b < BEW; b++) begin
                mrg_s[b*8 +: 8] = (hit_s & wr_be[b]) ? wr_data[b*8 +: 8] : old_s[b*8 +: 8];
            end
            vld_d = rd_en[p] & in_rng_s & ~busy_s & (ent_vld_s | (hit_s & wr_any_be_s));
            if (vld_d) begin
                dat_d = mrg_s;
            end else begin
                dat_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign rd_vld[p]                    = vld_q;
        assign rd_data[p*DWIDTH +: DWIDTH]  = dat_q;
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_arf_latch_rf_bank.sv
// Scoreboard bench for arf_latch_rf_bank: a per-cycle behavioural model queues expected
// outputs while a separate monitor compares them after each rising edge.
module tb_arf_latch_rf_bank;

    localparam int DW  = 64;
    localparam int DEP = 66;
    localparam int AW  = 7;
    localparam int NP  = 2;
    localparam bit BYP = 1'b1;

    typedef struct packed {
        logic [NP-1:0][DW-1:0] d;
        logic [NP-1:0]         v;
        logic                  busy;
        logic                  err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [7:0]        wr_be = '0;
    logic [NP-1:0]     rd_en = '0;
    logic [NP*AW-1:0]  rd_addr = '0;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_vld;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic              wr_err;

    exp_t              exp_q[$];
    logic [DW-1:0]     m_mem [DEP];
    bit                m_vld [DEP];
    int                clr_left = 0;
    int                clr_idx = 0;
    int                n_chk = 0;
    int                n_fail = 0;

    arf_latch_rf_bank #(.DWIDTH(DW), .DEPTH(DEP), .NRD(NP), .BYPASS(BYP)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_vld(rd_vld), .clr_req(clr_req), .clr_busy(clr_busy), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [7:0] be);
        for (int b = 0; b < 8; b++) if (be[b]) o[b*8 +: 8] = n[b*8 +: 8];
        return o;
    endfunction

    // Reference behaviour for the edge about to happen, from the bank's architectural rules.
    task automatic model_step();
        exp_t        e;
        bit          busy, wr_ok, v;
        int          a;
        logic [DW-1:0] d;
        e = '0;
        if (rst) begin
            for (int i = 0; i < DEP; i++) m_vld[i] = 0;
            clr_left = 0;
            clr_idx  = 0;
        end else begin
            busy  = (clr_left > 0);
            wr_ok = wr_en && (int'(wr_addr) < DEP) && !busy;
            e.err = wr_en && !wr_ok;
            for (int p = 0; p < NP; p++) begin
                a = int'(rd_addr[p*AW +: AW]);
                if (rd_en[p] && a < DEP && !busy) begin
                    d = m_mem[a];
                    v = m_vld[a];
                    if (BYP && wr_ok && int'(wr_addr) == a && wr_be != 8'h00) begin
                        d = merge(d, wr_data, wr_be);
                        v = 1;
                    end
                    if (v) begin
                        e.v[p] = 1'b1;
                        e.d[p] = d;
                    end
                end
            end
            if (wr_ok && wr_be != 8'h00) begin
                m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
                m_vld[wr_addr] = 1;
            end
            if (busy) begin
                m_mem[clr_idx] = '0;
                m_vld[clr_idx] = 0;
                clr_idx++;
                clr_left--;
            end else if (clr_req) begin
                clr_left = DEP;
                clr_idx  = 0;
            end
            e.busy = (clr_left > 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic [7:0] be, input logic [1:0] re, input int ra0, input int ra1,
                        input logic cr);
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = {AW'(ra1), AW'(ra0)};
        clr_req = cr;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 8'h00, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 7));
        if (r == 7) return int'($urandom_range(DEP - 2, DEP + 1));
        return int'($urandom_range(0, 127));
    endfunction

    // Monitor: every registered output is compared against the queued expectation after each rise.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NP; p++) begin
                    chk($sformatf("rd_vld[%0d]", p), DW'(rd_vld[p]), DW'(e.v[p]));
                    chk($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], e.d[p]);
                end
                chk("clr_busy", DW'(clr_busy), DW'(e.busy));
                chk("wr_err", DW'(wr_err), DW'(e.err));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEP; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 0;
        end
        // Reset cycles with traffic that must be ignored.
        step(1'b1, 1'b1, 5, 64'hDEAD_BEEF_0000_1111, 8'hFF, 2'b11, 0, DEP - 1, 1'b1);
        step(1'b1, 1'b0, 0, '0, 8'h00, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 0, DEP - 1, 1'b0);
        // Initial clear so latch contents are known.
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b00, 0, 0, 1'b1);
        idle(DEP + 2);
        // Byte-enable merge.
        step(1'b0, 1'b1, 5, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 5, 5, 1'b0);
        // Same-edge write and read.
        step(1'b0, 1'b1, 3, 64'h5555_5555_5555_5555, 8'hFF, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b1, 3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 2'b11, 3, 3, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 3, 5, 1'b0);
        // Dropped writes: out of range, then during clear.
        step(1'b0, 1'b1, DEP, 64'h1111_2222_3333_4444, 8'hFF, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 5, 3, 1'b1);
        step(1'b0, 1'b1, 5, 64'h7777_7777_7777_7777, 8'hFF, 2'b11, 5, 3, 1'b1);
        idle(DEP + 1);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 5, 3, 1'b0);
        // Fill, clear, read every entry.
        for (int i = 0; i < DEP; i++)
            step(1'b0, 1'b1, i, {$urandom, $urandom}, 8'hFF, 2'b01, (i + DEP - 1) % DEP, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 0, DEP - 1, 1'b1);
        idle(DEP + 1);
        for (int i = 0; i < DEP; i++)
            step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, i, DEP - 1 - i, 1'b0);
        // Reset in the middle of a clear.
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, i, {$urandom, $urandom}, 8'hFF, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b00, 0, 0, 1'b1);
        idle(5);
        step(1'b1, 1'b0, 0, '0, 8'h00, 2'b11, 7, 7, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 7, 11, 1'b0);
        step(1'b0, 1'b1, 7, 64'hCAFE_F00D_1234_5678, 8'hFF, 2'b00, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, '0, 8'h00, 2'b11, 7, 7, 1'b0);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), $urandom_range(0, 1), pick_addr(),
                 {$urandom, $urandom}, (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)),
                 2'($urandom), pick_addr(), pick_addr(), ($urandom_range(0, 99) == 0));
        end
        idle(2);
        @(negedge clk);
        chk("scoreboard_drain", DW'(exp_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
